// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared I2C definitions used by the bus master and the slave
//               side: FSM state encoding, SCL quarter-phase codes and the
//               acknowledge bit levels.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] IDLE  = 4'd0;
    localparam logic [STATE_W-1:0] START = 4'd1;
    localparam logic [STATE_W-1:0] ADDR  = 4'd2;
    localparam logic [STATE_W-1:0] ACK1  = 4'd3;
    localparam logic [STATE_W-1:0] WDATA = 4'd4;
    localparam logic [STATE_W-1:0] RDATA = 4'd5;
    localparam logic [STATE_W-1:0] ACK2  = 4'd6;
    localparam logic [STATE_W-1:0] MACK  = 4'd7;
    localparam logic [STATE_W-1:0] STOP  = 4'd8;

    // Quarter phases of one SCL bit period
    localparam logic [1:0] Q0 = 2'd0;   // SCL low, SDA may change
    localparam logic [1:0] Q1 = 2'd1;   // SCL rises
    localparam logic [1:0] Q2 = 2'd2;   // SCL high, SDA sampled
    localparam logic [1:0] Q3 = 2'd3;   // SCL falls

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_clk_gen
// Description : Quarter-period timebase for the I2C master. Emits a one-cycle
//               tick every CLK_DIV clocks and advances a 2-bit phase on each
//               tick. Held at phase Q0 / count 0 while i_clr is high.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               i_clr        - synchronous hold-in-reset (master idle)
//               o_tick       - last clock of the current quarter
//               o_phase      - current quarter phase Q0..Q3
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    output logic       o_tick,
    output logic [1:0] o_phase
);

    localparam logic [7:0] c_cnt_last = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic [1:0] r_phase;

    assign o_tick  = !i_clr && (r_cnt == c_cnt_last);
    assign o_phase = r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 8'd0;
            r_phase <= Q0;
        end else if (i_clr) begin
            r_cnt   <= 8'd0;
            r_phase <= Q0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt   <= 8'd0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_cnt   <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master
// Description : Single-byte I2C bus master. One command = START, address
//               byte {addr, rw}, one data byte (write or read), STOP.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               start         - command strobe, honoured only when idle
//               rw/addr/wdata - command fields captured with start
//               rdata         - byte read, updated when a read completes
//               busy/done     - transaction in flight / one-cycle completion
//               ack_err       - address or write-data NACK, valid with done
//               scl           - push-pull bus clock
//               sda           - open-drain bus data (drives 0 or z only)
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;

    logic       w_tick;
    logic [1:0] w_phase;
    logic       w_end_tick;      // last clock of a bit period
    logic       w_sample_tick;   // last clock of Q2, SCL high
    logic       w_accept;

    logic [7:0] r_addr_rw;
    logic [7:0] r_wdata;
    logic [7:0] r_rx;
    logic [2:0] r_bit;
    logic       r_sample;

    logic       w_scl;
    logic       w_sda_low;

    i2c_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (r_state == IDLE),
        .o_tick  (w_tick),
        .o_phase (w_phase)
    );

    assign w_end_tick    = w_tick && (w_phase == Q3);
    assign w_sample_tick = w_tick && (w_phase == Q2);
    // done is high in the first idle cycle; a start there is dropped
    assign w_accept      = (r_state == IDLE) && start && !done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: every non-idle state advances at a bit boundary
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next_state = START;
            START: if (w_end_tick) w_next_state = ADDR;
            ADDR:  if (w_end_tick && (r_bit == 3'd0)) w_next_state = ACK1;
            ACK1: begin
                if (w_end_tick) begin
                    if (r_sample == NACK)  w_next_state = STOP;
                    else if (r_addr_rw[0]) w_next_state = RDATA;
                    else                   w_next_state = WDATA;
                end
            end
            WDATA: if (w_end_tick && (r_bit == 3'd0)) w_next_state = ACK2;
            RDATA: if (w_end_tick && (r_bit == 3'd0)) w_next_state = MACK;
            ACK2:  if (w_end_tick) w_next_state = STOP;
            MACK:  if (w_end_tick) w_next_state = STOP;
            STOP:  if (w_end_tick) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus outputs. Data bits change only in Q0/Q3 (SCL low); START pulls
    // SDA at Q2 and STOP releases it at Q2, both with SCL high.
    // ------------------------------------------------------------------
    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        case (r_state)
            IDLE: begin
                w_scl     = 1'b1;
                w_sda_low = 1'b0;
            end
            START: begin
                w_scl     = (w_phase != Q3);
                w_sda_low = (w_phase == Q2) || (w_phase == Q3);
            end
            ADDR: begin
                w_scl     = (w_phase == Q1) || (w_phase == Q2);
                w_sda_low = !r_addr_rw[r_bit];
            end
            WDATA: begin
                w_scl     = (w_phase == Q1) || (w_phase == Q2);
                w_sda_low = !r_wdata[r_bit];
            end
            ACK1, ACK2, RDATA, MACK: begin
                // released: slave drives ACK / read data; MACK is a NACK
                w_scl     = (w_phase == Q1) || (w_phase == Q2);
                w_sda_low = 1'b0;
            end
            STOP: begin
                w_scl     = (w_phase != Q0);
                w_sda_low = (w_phase == Q0) || (w_phase == Q1);
            end
            default: begin
                w_scl     = 1'b1;
                w_sda_low = 1'b0;
            end
        endcase
    end

    assign scl = w_scl;
    assign sda = w_sda_low ? 1'b0 : 1'bz;

    // ------------------------------------------------------------------
    // Command capture, bit counting, sampling and completion
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_rw <= 8'd0;
            r_wdata   <= 8'd0;
            r_rx      <= 8'd0;
            r_bit     <= 3'd7;
            r_sample  <= NACK;
            rdata     <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (w_accept) begin
                r_addr_rw <= {addr, rw};
                r_wdata   <= wdata;
                r_bit     <= 3'd7;
                busy      <= 1'b1;
                ack_err   <= 1'b0;
            end

            if (w_sample_tick) begin
                r_sample <= sda;
                if (r_state == RDATA) begin
                    r_rx <= {r_rx[6:0], sda};
                end
                if (((r_state == ACK1) || (r_state == ACK2)) && (sda == NACK)) begin
                    ack_err <= 1'b1;
                end
            end

            // 3-bit counter wraps 0 -> 7, ready for the next byte
            if (w_end_tick && ((r_state == ADDR) || (r_state == WDATA) || (r_state == RDATA))) begin
                r_bit <= r_bit - 3'd1;
            end

            if (w_end_tick && (r_state == STOP)) begin
                done <= 1'b1;
                busy <= 1'b0;
                if (r_addr_rw[0] && !ack_err) begin
                    rdata <= r_rx;
                end
            end
        end
    end

endmodule
`default_nettype wire
